// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit hex scanner: digit count, dark pattern
// and the nibble-to-segment table (gfedcba, active-low).
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry 0 sits in the least-significant slot, so HEX_SEG[nibble] is the pattern.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_frame_scanner.sv
// Multiplexes a 32-bit word onto an 8-digit common-anode display; new words
// are held pending and swapped in only at a frame boundary to avoid tearing.
module seg7_frame_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 99999,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  input  logic [7:0]  i_dp,
  output logic [7:0]  o_seg,
  output logic [7:0]  o_sel,
  output logic        o_frame
);

  localparam int DIV_W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
  localparam int IDX_W = $clog2(DIGITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_n;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [7:0]       pend_dp_q, pend_dp_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [7:0]       disp_dp_q, disp_dp_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       sel_q, sel_d;
  logic             frame_q;

  logic             tick;
  logic             wrap;
  logic             accept;
  logic             commit;
  logic [DIGITS-1:0] upper_zero;
  logic [3:0]       nibble_n;
  logic             blank_n;
  logic [6:0]       dec_seg;

  assign tick    = (div_cnt_q == DIV_W'(SCAN_DIV));
  assign wrap    = tick && (idx_q == IDX_W'(DIGITS - 1));
  assign o_ready = ~pend_v_q;
  assign accept  = i_valid && o_ready;
  assign commit  = wrap && pend_v_q;
  assign idx_n   = idx_q + 1'b1;

  // Output logic reads the post-commit view so digit 0 of a new frame is already fresh.
  assign disp_data_d = commit ? pend_data_q : disp_data_q;
  assign disp_dp_d   = commit ? pend_dp_q   : disp_dp_q;

  // upper_zero[k]: nibbles k..7 of the displayed word are all zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign upper_zero[gi] = (disp_data_d[31:gi*4] == '0);
  end

  assign nibble_n = disp_data_d[{idx_n, 2'b00} +: 4];
  assign blank_n  = BLANK_LZ && (idx_n != '0) && upper_zero[idx_n];

  seg7_hex_decode u_hex_decode (
    .nibble_i (nibble_n),
    .blank_i  (blank_n),
    .seg_o    (dec_seg)
  );

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
    idx_d       = tick ? idx_n : idx_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_v_d    = pend_v_q;
    sel_d       = sel_q;
    seg_d       = seg_q;
    if (accept) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      pend_v_d    = 1'b1;
    end else if (commit) begin
      pend_v_d    = 1'b0;
    end
    if (tick) begin
      sel_d = ~(8'b1 << idx_n);
      seg_d = {~disp_dp_d[idx_n], dec_seg};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q   <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_v_q    <= 1'b0;
      disp_data_q <= '0;
      disp_dp_q   <= '0;
      seg_q       <= SEG_OFF;
      sel_q       <= SEG_OFF;
      frame_q     <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_v_q    <= pend_v_d;
      disp_data_q <= disp_data_d;
      disp_dp_q   <= disp_dp_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= wrap;
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule
